// File: rtl/issue_pkg.sv
// Shared definitions for the opcode issue controller: opcode width, queue entry layout and
// a constant-evaluable ceil(log2) helper.
package issue_pkg;

    localparam int unsigned OPCODE_W     = 8;
    localparam int unsigned PC_W_DEFAULT = 16;

    typedef struct packed {
        logic [OPCODE_W-1:0]     opcode;
        logic [PC_W_DEFAULT-1:0] pc;
    } issue_entry_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/issue_fifo.sv
// Synchronous FIFO with clear; head is read combinationally from the storage array.
module issue_fifo
    import issue_pkg::*;
#(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 24
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clr_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [Width-1:0]           wdata_i,
    output logic [Width-1:0]           rdata_o,
    output logic [clog2(Depth+1)-1:0]  count_o
);

    localparam int unsigned PtrW = clog2(Depth);
    localparam int unsigned CntW = clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop, full;

    always_comb begin
        full     = (count_q == CntW'(Depth));
        do_push  = push_i & !clr_i;
        do_pop   = pop_i & !clr_i & (count_q != '0);
        rd_ptr_d = rd_ptr_q + PtrW'(do_pop);
        wr_ptr_d = wr_ptr_q + PtrW'(do_push);
        count_d  = count_q + CntW'(do_push) - CntW'(do_pop);
        if (clr_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
            end
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Credit accounting upstream guarantees a free slot for every accepted return.
    push_into_full: assert property (@(posedge clk_i) disable iff (rst_i) !(do_push && full));

endmodule

// File: rtl/opcode_issue.sv
// Opcode prefetch and issue controller: credit-based byte prefetch into a small queue,
// dispatch gating towards the microcode sequencer, and redirect flush with stale-return drop.
module opcode_issue
    import issue_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter int unsigned     PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    output logic                fetch_req,
    output logic [PC_W-1:0]     fetch_addr,
    input  logic                fetch_valid,
    input  logic [OPCODE_W-1:0] fetch_data,
    input  logic                redirect,
    input  logic [PC_W-1:0]     redirect_pc,
    input  logic                mc__more,
    input  logic                issue_hold,
    output logic [OPCODE_W-1:0] opcode,
    output logic [PC_W-1:0]     issue_pc,
    output logic                mc__stall
);

    localparam int unsigned CntW    = clog2(DEPTH + 1);
    // Back-to-back redirects can stack stale returns beyond DEPTH, so leave headroom.
    localparam int unsigned FlightW = clog2(DEPTH) + 5;
    localparam int unsigned SumW    = FlightW + 1;
    localparam int unsigned EntryW  = OPCODE_W + PC_W;

    logic [FlightW-1:0] inflight_q, inflight_d;
    logic [FlightW-1:0] discard_q, discard_d;
    logic [PC_W-1:0]    fetch_addr_q, fetch_addr_d;
    logic [PC_W-1:0]    ret_pc_q, ret_pc_d;
    logic [CntW-1:0]    count;
    logic [EntryW-1:0]  head, wentry;
    logic [SumW-1:0]    credit_used;
    logic               push, pop;

    always_comb begin
        mc__stall   = redirect | (!mc__more & ((count == '0) | issue_hold));
        pop         = !mc__more & !mc__stall;
        credit_used = SumW'(count) + SumW'(inflight_q) - SumW'(discard_q);
        fetch_req   = !redirect & (credit_used < SumW'(DEPTH));
        push        = fetch_valid & !redirect & (discard_q == '0);
        wentry      = {fetch_data, ret_pc_q};

        fetch_addr_d = fetch_addr_q;
        ret_pc_d     = ret_pc_q;
        inflight_d   = inflight_q;
        discard_d    = discard_q;

        if (redirect) begin
            fetch_addr_d = redirect_pc;
            ret_pc_d     = redirect_pc;
            inflight_d   = inflight_q - FlightW'(fetch_valid);
            discard_d    = inflight_q - FlightW'(fetch_valid);
        end else begin
            inflight_d = inflight_q + FlightW'(fetch_req) - FlightW'(fetch_valid);
            if (fetch_req) begin
                fetch_addr_d = fetch_addr_q + PC_W'(1);
            end
            if (fetch_valid && (discard_q != '0)) begin
                discard_d = discard_q - FlightW'(1);
            end
            if (push) begin
                ret_pc_d = ret_pc_q + PC_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q   <= '0;
            discard_q    <= '0;
            fetch_addr_q <= RESET_PC;
            ret_pc_q     <= RESET_PC;
        end else begin
            inflight_q   <= inflight_d;
            discard_q    <= discard_d;
            fetch_addr_q <= fetch_addr_d;
            ret_pc_q     <= ret_pc_d;
        end
    end

    issue_fifo #(
        .Depth (DEPTH),
        .Width (EntryW)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .clr_i   (redirect),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wentry),
        .rdata_o (head),
        .count_o (count)
    );

    assign fetch_addr = fetch_addr_q;
    assign opcode     = head[EntryW-1:PC_W];
    assign issue_pc   = head[PC_W-1:0];

    inflight_overflow: assert property (@(posedge clk) disable iff (rst)
        !(fetch_req && !fetch_valid && (inflight_q == '1)));

endmodule

// File: tb/tb_opcode_issue.sv
// Bench for opcode_issue: in-order memory model with programmable latency, expected program
// stream scoreboard checked on every dispatch, plus directed timing scenarios.
module tb_opcode_issue;
    import issue_pkg::*;

    localparam int unsigned     DEPTH    = 4;
    localparam int unsigned     PC_W     = 16;
    localparam logic [PC_W-1:0] RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst, fetch_req, fetch_valid, redirect, mc__more, issue_hold, mc__stall;
    logic [15:0] fetch_addr, redirect_pc, issue_pc;
    logic [7:0]  fetch_data, opcode;

    always #5 clk = ~clk;

    opcode_issue #(
        .DEPTH    (DEPTH),
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_valid (fetch_valid),
        .fetch_data  (fetch_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mc__more    (mc__more),
        .issue_hold  (issue_hold),
        .opcode      (opcode),
        .issue_pc    (issue_pc),
        .mc__stall   (mc__stall)
    );

    typedef struct {
        logic [15:0] addr;
        int          ready;
        bit          live;
    } req_t;

    req_t         pend[$];
    issue_entry_t exp_q[$];
    int           cyc = 0, n_cmp = 0, n_err = 0, n_disp = 0;
    int           lat_min = 1, lat_max = 1, last_ready = 0;
    logic [15:0]  next_pc = 16'h0, exp_req_addr = 16'h0;
    bit           cur_live = 1'b0;

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return (a[7:0] + 8'h10) ^ a[15:8];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected program stream: sequential bytes from the last redirect/reset target.
    task automatic refill();
        issue_entry_t e;
        while (exp_q.size() < 8) begin
            e.opcode = mem_byte(next_pc);
            e.pc     = next_pc;
            exp_q.push_back(e);
            next_pc  = next_pc + 16'd1;
        end
    endtask

    task automatic tick();
        req_t r;
        @(posedge clk);
        cyc++;
        #1;
        redirect    = 1'b0;
        fetch_valid = 1'b0;
        cur_live    = 1'b0;
        if (!rst && pend.size() > 0 && pend[0].ready <= cyc) begin
            r           = pend.pop_front();
            fetch_valid = 1'b1;
            fetch_data  = mem_byte(r.addr);
            cur_live    = r.live;
        end
        refill();
    endtask

    task automatic do_redirect(input logic [15:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        for (int i = 0; i < pend.size(); i++) pend[i].live = 1'b0;
        cur_live     = 1'b0;
        exp_q.delete();
        next_pc      = pc;
        exp_req_addr = pc;
        refill();
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 16'h0;
        mc__more    = 1'b0;
        issue_hold  = 1'b0;
        fetch_valid = 1'b0;
        fetch_data  = 8'h0;
        pend.delete();
        last_ready  = 0;
        repeat (3) tick();
        rst = 1'b0;
        exp_q.delete();
        next_pc      = RESET_PC;
        exp_req_addr = RESET_PC;
        refill();
    endtask

    // Memory side: record requests, check address order and live-credit limit.
    always @(negedge clk) begin : mem_mon
        int   live_n;
        int   ready;
        req_t r;
        if (!rst && fetch_req) begin
            live_n = (fetch_valid && cur_live) ? 1 : 0;
            foreach (pend[i]) if (pend[i].live) live_n++;
            check("req_credit", live_n < int'(DEPTH), 1);
            check("req_addr", fetch_addr, exp_req_addr);
            exp_req_addr = exp_req_addr + 16'd1;
            ready = cyc + int'($urandom_range(lat_max, lat_min));
            if (ready < last_ready) ready = last_ready;
            last_ready = ready;
            r.addr  = fetch_addr;
            r.ready = ready;
            r.live  = 1'b1;
            pend.push_back(r);
        end
    end

    // Dispatch side: every dispatched opcode must be the next one of the program stream.
    always @(negedge clk) begin : disp_mon
        issue_entry_t e;
        if (!rst && !mc__more && !mc__stall) begin
            n_disp++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL dispatch: got pc 0x%0h, want no dispatch", issue_pc);
            end else begin
                e = exp_q.pop_front();
                check("dispatch", {opcode, issue_pc}, {e.opcode, e.pc});
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int d0, redir_cyc, found;
        rst = 1'b1;

        // Latency 1 from reset: first request, first opcode, steady throughput.
        lat_min = 1; lat_max = 1;
        do_reset();
        @(negedge clk);
        check("rst_opcode", opcode, 8'h00);
        check("rst_issue_pc", issue_pc, 16'h0000);
        check("rst_stall", mc__stall, 1'b1);
        check("rst_fetch_req", fetch_req, 1'b1);
        check("rst_fetch_addr", fetch_addr, RESET_PC);
        tick(); @(negedge clk);
        check("no_bypass_stall", mc__stall, 1'b1);
        tick(); @(negedge clk);
        check("first_opcode", opcode, 8'h10);
        check("first_pc", issue_pc, 16'h0000);
        check("first_dispatch", mc__stall, 1'b0);
        tick();
        d0 = n_disp;
        repeat (10) tick();
        check("throughput", n_disp - d0, 10);

        // Latency 8: credit limit, and stall behaviour against mc__more with empty queue.
        lat_min = 8; lat_max = 8;
        do_reset();
        mc__more = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            if (i > 3) mc__more = 1'b0;
            @(negedge clk);
            check("lat8_req", fetch_req, (i <= 4));
            if (i <= 3) check("more_no_stall", mc__stall, 1'b0);
            else        check("empty_stall", mc__stall, 1'b1);
            tick();
        end
        @(negedge clk);
        check("lat8_arrival_dispatch", mc__stall, 1'b0);
        check("lat8_arrival_pc", issue_pc, 16'h0000);
        repeat (40) tick();

        // Redirect with three requests outstanding and a return in the same cycle.
        lat_min = 3; lat_max = 3;
        do_reset();
        repeat (3) tick();
        do_redirect(16'h0200);
        redir_cyc = cyc;
        @(negedge clk);
        check("redir_stall", mc__stall, 1'b1);
        check("redir_no_req", fetch_req, 1'b0);
        tick(); @(negedge clk);
        check("redir_first_req", fetch_req, 1'b1);
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            tick(); @(negedge clk);
            if (!mc__stall && !mc__more) found = 1;
        end
        check("redir_target_seen", found, 1);
        check("redir_target_pc", issue_pc, 16'h0200);
        check("redir_latency", cyc - redir_cyc, 5);
        repeat (20) tick();

        // Hold with a full queue: nothing moves, then dispatch resumes on release.
        lat_min = 1; lat_max = 1;
        do_reset();
        issue_hold = 1'b1;
        repeat (5) tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_no_req", fetch_req, 1'b0);
            check("hold_head", {opcode, issue_pc}, {mem_byte(16'h0), 16'h0000});
            check("hold_stall", mc__stall, 1'b1);
            tick();
        end
        issue_hold = 1'b0;
        @(negedge clk);
        check("release_dispatch", mc__stall, 1'b0);
        repeat (10) tick();

        // Address wrap at the top of the PC space.
        lat_min = 1; lat_max = 3;
        do_reset();
        tick();
        do_redirect(16'hFFFD);
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            tick(); @(negedge clk);
            if (!mc__stall && !mc__more && issue_pc == 16'h0000) found = 1;
        end
        check("wrap_dispatch_seen", found, 1);

        // Random traffic: latency, mc__more, hold, redirects and one mid-fetch reset.
        lat_min = 1; lat_max = 6;
        do_reset();
        d0 = n_disp;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (i == 1500) begin
                do_reset();
            end else begin
                mc__more   = ($urandom_range(99, 0) < 30);
                issue_hold = ($urandom_range(99, 0) < 20);
                if ($urandom_range(99, 0) < 3) begin
                    if ($urandom_range(3, 0) == 0) do_redirect(16'hFFF0 + 16'($urandom_range(15, 0)));
                    else                           do_redirect(16'($urandom));
                end
            end
        end
        check("random_progress", (n_disp - d0) > 500, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
